// File: rtl/peak_tracker_fsm_pkg.sv
// Shared definitions for the running-extreme tracker: state encoding,
// tracking-mode selectors and helpers for the mode-dependent constant values.
package peak_tracker_fsm_pkg;

    // Tracker state encoding
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_TRACK = 2'd1;
    localparam logic [1:0] ST_SAT   = 2'd2;

    // Tracking direction
    localparam int MODE_MAX = 0;
    localparam int MODE_MIN = 1;

    // All-ones pattern of the given width (callers truncate to their width)
    function automatic logic [63:0] ones_value(input int width);
        logic [63:0] ones;
        ones = (width >= 64) ? '1 : ((64'd1 << width) - 64'd1);
        return ones;
    endfunction

    // Value at which the extreme can no longer improve
    function automatic logic [63:0] sat_value(input int width, input int mode);
        return (mode == MODE_MIN) ? 64'd0 : ones_value(width);
    endfunction

    // Value held in peak before any sample has been accepted
    function automatic logic [63:0] start_value(input int width, input int mode);
        return (mode == MODE_MIN) ? ones_value(width) : 64'd0;
    endfunction

endpackage

// File: rtl/peak_tracker_fsm_if.sv
// Sample stream in, tracker status out.
interface peak_tracker_fsm_if #(
    parameter int WIDTH = 8,
    parameter int IDX_W = 8
);
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             clear;
    logic [WIDTH-1:0] peak;
    logic [IDX_W-1:0] peak_idx;
    logic [IDX_W-1:0] count;
    logic             new_peak;
    logic             seen;
    logic             sat;

    // Sample source / monitor side
    modport master (
        output in_valid, in_data, clear,
        input  peak, peak_idx, count, new_peak, seen, sat
    );

    // Tracker side
    modport slave (
        input  in_valid, in_data, clear,
        output peak, peak_idx, count, new_peak, seen, sat
    );
endinterface

// File: rtl/peak_tracker_fsm_sat_counter.sv
// Saturating up-counter. A clear coinciding with an enable restarts the
// count at one, so the sample that arrives with the clear is still counted.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         clear,
    input  logic         en,
    output logic [W-1:0] value
);
    localparam logic [W-1:0] MAX_VAL = '1;

    logic [W-1:0] value_reg;

    // Count enabled events, hold at all-ones instead of wrapping
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            value_reg <= '0;
        end else if (clear) begin
            value_reg <= en ? W'(1) : '0;
        end else if (en && (value_reg != MAX_VAL)) begin
            value_reg <= value_reg + W'(1);
        end
    end

    assign value = value_reg;
endmodule

// File: rtl/peak_tracker_fsm.sv
// Running-extreme tracker: follows the maximum (or minimum) of a qualified
// sample stream, remembers where it first occurred, and parks in an
// absorbing state once the extreme reaches the end of the value range.
module peak_tracker_fsm
    import peak_tracker_fsm_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int IDX_W = 8,
    parameter int MODE  = 0
) (
    input  logic                clk,
    input  logic                rstn,
    peak_tracker_fsm_if.slave   bus
);
    localparam logic [WIDTH-1:0] SAT_VAL   = WIDTH'(sat_value(WIDTH, MODE));
    localparam logic [WIDTH-1:0] START_VAL = WIDTH'(start_value(WIDTH, MODE));

    logic [1:0]       state_reg, state_next;
    logic [WIDTH-1:0] peak_reg, peak_next;
    logic [IDX_W-1:0] idx_reg, idx_next;
    logic             new_peak_reg, new_peak_next;
    logic             seen_reg, seen_next;
    logic             sat_reg, sat_next;
    logic [IDX_W-1:0] count_val;
    logic             better;

    // Accepted-sample counter; its pre-increment value is the index of
    // the sample currently being presented
    sat_counter #(.W(IDX_W)) u_count (
        .clk   (clk),
        .rstn  (rstn),
        .clear (bus.clear),
        .en    (bus.in_valid),
        .value (count_val)
    );

    // Strict comparison so that ties keep the earlier index
    always_comb begin
        if (MODE == MODE_MIN) begin
            better = (bus.in_data < peak_reg);
        end else begin
            better = (bus.in_data > peak_reg);
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_next    = state_reg;
        peak_next     = peak_reg;
        idx_next      = idx_reg;
        new_peak_next = 1'b0;
        seen_next     = seen_reg;
        sat_next      = sat_reg;

        if (bus.clear || (bus.in_valid && (state_reg == ST_IDLE))) begin
            if (bus.in_valid) begin
                // First sample after reset/clear is taken unconditionally
                peak_next     = bus.in_data;
                idx_next      = '0;
                new_peak_next = 1'b1;
                seen_next     = 1'b1;
                sat_next      = (bus.in_data == SAT_VAL);
                state_next    = (bus.in_data == SAT_VAL) ? ST_SAT : ST_TRACK;
            end else begin
                state_next = ST_IDLE;
                peak_next  = START_VAL;
                idx_next   = '0;
                seen_next  = 1'b0;
                sat_next   = 1'b0;
            end
        end else begin
            case (state_reg)
                ST_IDLE: ;
                ST_TRACK: begin
                    if (bus.in_valid && better) begin
                        peak_next     = bus.in_data;
                        idx_next      = count_val;
                        new_peak_next = 1'b1;
                        if (bus.in_data == SAT_VAL) begin
                            state_next = ST_SAT;
                            sat_next   = 1'b1;
                        end
                    end
                end
                ST_SAT: ;
                default: begin
                    // Unused encoding: restart tracking cleanly
                    state_next = ST_IDLE;
                    peak_next  = START_VAL;
                    idx_next   = '0;
                    seen_next  = 1'b0;
                    sat_next   = 1'b0;
                end
            endcase
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg    <= ST_IDLE;
            peak_reg     <= START_VAL;
            idx_reg      <= '0;
            new_peak_reg <= 1'b0;
            seen_reg     <= 1'b0;
            sat_reg      <= 1'b0;
        end else begin
            state_reg    <= state_next;
            peak_reg     <= peak_next;
            idx_reg      <= idx_next;
            new_peak_reg <= new_peak_next;
            seen_reg     <= seen_next;
            sat_reg      <= sat_next;
        end
    end

    assign bus.peak     = peak_reg;
    assign bus.peak_idx = idx_reg;
    assign bus.count    = count_val;
    assign bus.new_peak = new_peak_reg;
    assign bus.seen     = seen_reg;
    assign bus.sat      = sat_reg;
endmodule

// File: tb/tb_peak_tracker_fsm.sv
// Bench for peak_tracker_fsm: three configurations (max 8/8, min 8/8,
// max 4/2) driven with directed and random samples, checked against a
// model that derives the expected status from the list of accepted samples.
module tb_peak_tracker_fsm;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rstn0, rstn1, rstn2;

    peak_tracker_fsm_if #(.WIDTH(8), .IDX_W(8)) bus0 ();
    peak_tracker_fsm_if #(.WIDTH(8), .IDX_W(8)) bus1 ();
    peak_tracker_fsm_if #(.WIDTH(4), .IDX_W(2)) bus2 ();

    peak_tracker_fsm #(.WIDTH(8), .IDX_W(8), .MODE(0)) dut0 (.clk(clk), .rstn(rstn0), .bus(bus0.slave));
    peak_tracker_fsm #(.WIDTH(8), .IDX_W(8), .MODE(1)) dut1 (.clk(clk), .rstn(rstn1), .bus(bus1.slave));
    peak_tracker_fsm #(.WIDTH(4), .IDX_W(2), .MODE(0)) dut2 (.clk(clk), .rstn(rstn2), .bus(bus2.slave));

    int w_a[3]  = '{8, 8, 4};
    int iw_a[3] = '{8, 8, 2};
    int md_a[3] = '{0, 1, 0};

    // Accepted samples since reset/clear, per configuration
    int q0[$];
    int q1[$];
    int q2[$];
    int np_exp[3] = '{0, 0, 0};

    int total  = 0;
    int passed = 0;
    int failed = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic get_q(input int sel, output int q[$]);
        case (sel)
            0: q = q0;
            1: q = q1;
            default: q = q2;
        endcase
    endtask

    task automatic set_q(input int sel, input int q[$]);
        case (sel)
            0: q0 = q;
            1: q1 = q;
            default: q2 = q;
        endcase
    endtask

    // Expected status from the accepted-sample list: extreme of the list,
    // first position holding it, saturating length
    task automatic model(input int q[$], input int sel, output int pk, output int idx,
                         output int cnt, output int sn, output int st);
        int maxc;
        int ones;
        int ext[$];
        int pos[$];
        maxc = (1 << iw_a[sel]) - 1;
        ones = (1 << w_a[sel]) - 1;
        cnt  = (q.size() > maxc) ? maxc : q.size();
        sn   = (q.size() > 0) ? 1 : 0;
        pk   = (md_a[sel] == 1) ? ones : 0;
        idx  = 0;
        st   = 0;
        if (q.size() > 0) begin
            if (md_a[sel] == 1) ext = q.min();
            else ext = q.max();
            pk  = ext[0];
            pos = q.find_first_index(x) with (x == pk);
            idx = (pos[0] > maxc) ? maxc : pos[0];
            st  = (pk == ((md_a[sel] == 1) ? 0 : ones)) ? 1 : 0;
        end
    endtask

    task automatic drive(input int sel, input bit v, input int d, input bit clr);
        case (sel)
            0: begin bus0.in_valid = v; bus0.in_data = 8'(d); bus0.clear = clr; end
            1: begin bus1.in_valid = v; bus1.in_data = 8'(d); bus1.clear = clr; end
            default: begin bus2.in_valid = v; bus2.in_data = 4'(d); bus2.clear = clr; end
        endcase
    endtask

    task automatic set_rstn(input int sel, input logic val);
        case (sel)
            0: rstn0 = val;
            1: rstn1 = val;
            default: rstn2 = val;
        endcase
    endtask

    task automatic check(input int sel, input string tag);
        int q[$];
        int pk, idx, cnt, sn, st;
        logic [31:0] o_pk, o_idx, o_cnt, o_np, o_sn, o_st;
        get_q(sel, q);
        model(q, sel, pk, idx, cnt, sn, st);
        case (sel)
            0: begin o_pk = 32'(bus0.peak); o_idx = 32'(bus0.peak_idx); o_cnt = 32'(bus0.count);
                     o_np = 32'(bus0.new_peak); o_sn = 32'(bus0.seen); o_st = 32'(bus0.sat); end
            1: begin o_pk = 32'(bus1.peak); o_idx = 32'(bus1.peak_idx); o_cnt = 32'(bus1.count);
                     o_np = 32'(bus1.new_peak); o_sn = 32'(bus1.seen); o_st = 32'(bus1.sat); end
            default: begin o_pk = 32'(bus2.peak); o_idx = 32'(bus2.peak_idx); o_cnt = 32'(bus2.count);
                     o_np = 32'(bus2.new_peak); o_sn = 32'(bus2.seen); o_st = 32'(bus2.sat); end
        endcase
        chk($sformatf("%s[%0d].peak", tag, sel), o_pk, 32'(pk));
        chk($sformatf("%s[%0d].peak_idx", tag, sel), o_idx, 32'(idx));
        chk($sformatf("%s[%0d].count", tag, sel), o_cnt, 32'(cnt));
        chk($sformatf("%s[%0d].new_peak", tag, sel), o_np, 32'(np_exp[sel]));
        chk($sformatf("%s[%0d].seen", tag, sel), o_sn, 32'(sn));
        chk($sformatf("%s[%0d].sat", tag, sel), o_st, 32'(st));
    endtask

    // One clock of stimulus on one configuration, then check it
    task automatic step(input int sel, input bit v, input int d, input bit clr, input string tag);
        int q[$];
        int pk0, i0, c0, s0, t0;
        int pk1, i1, c1, s1, t1;
        int dm;
        bit empty;
        dm = d & ((1 << w_a[sel]) - 1);
        drive(sel, v, dm, clr);
        @(posedge clk);
        #1;
        drive(sel, 1'b0, 0, 1'b0);
        get_q(sel, q);
        model(q, sel, pk0, i0, c0, s0, t0);
        if (clr) q.delete();
        empty = (q.size() == 0);
        if (v) q.push_back(dm);
        model(q, sel, pk1, i1, c1, s1, t1);
        np_exp[sel] = (v && (empty || (pk1 != pk0))) ? 1 : 0;
        set_q(sel, q);
        check(sel, tag);
    endtask

    // Assert reset mid-cycle with a sample pending; outputs must drop at once
    task automatic reset_async(input int sel, input bit v, input int d);
        int q[$];
        drive(sel, v, d, 1'b0);
        #2;
        set_rstn(sel, 1'b0);
        set_q(sel, q);
        np_exp[sel] = 0;
        #1;
        check(sel, "async_rst");
        @(posedge clk);
        #1;
        check(sel, "rst_hold");
        set_rstn(sel, 1'b1);
        drive(sel, 1'b0, 0, 1'b0);
    endtask

    initial begin
        int r;
        int d;
        bit v;
        bit c;
        rstn0 = 1'b0; rstn1 = 1'b0; rstn2 = 1'b0;
        for (int s = 0; s < 3; s++) drive(s, 1'b0, 0, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1;
        for (int s = 0; s < 3; s++) check(s, "reset");
        rstn0 = 1'b1; rstn1 = 1'b1; rstn2 = 1'b1;

        // Max tracking basic sequence
        step(0, 1, 5, 0, "tp1");
        step(0, 1, 3, 0, "tp1");
        step(0, 1, 9, 0, "tp1");
        step(0, 1, 9, 0, "tp1");
        step(0, 0, 0, 0, "tp1_idle");
        step(0, 1, 2, 0, "tp1");
        chk("tp1.peak_const", 32'(bus0.peak), 32'd9);
        chk("tp1.idx_const", 32'(bus0.peak_idx), 32'd2);
        chk("tp1.count_const", 32'(bus0.count), 32'd5);

        // Clear alone, then saturation at all-ones
        step(0, 0, 0, 1, "clear_alone");
        step(0, 1, 10, 0, "tp2");
        step(0, 1, 255, 0, "tp2");
        chk("tp2.sat_const", 32'(bus0.sat), 32'd1);
        step(0, 1, 7, 0, "tp2");
        step(0, 1, 255, 0, "tp2");
        chk("tp2.count_const", 32'(bus0.count), 32'd4);

        // Clear coinciding with a sample
        step(0, 0, 0, 1, "tp5");
        step(0, 1, 50, 0, "tp5");
        step(0, 1, 200, 0, "tp5");
        step(0, 1, 30, 0, "tp5");
        step(0, 1, 77, 1, "tp5_clrv");
        chk("tp5.peak_const", 32'(bus0.peak), 32'd77);
        chk("tp5.count_const", 32'(bus0.count), 32'd1);
        chk("tp5.np_const", 32'(bus0.new_peak), 32'd1);

        // Async reset while saturated with a sample pending
        step(0, 1, 255, 0, "tp6");
        reset_async(0, 1, 100);
        step(0, 1, 4, 0, "tp6_after");
        chk("tp6.peak_const", 32'(bus0.peak), 32'd4);
        step(0, 1, 6, 0, "tp6_track");

        // Min tracking
        step(1, 1, 40, 0, "tp3");
        step(1, 1, 12, 0, "tp3");
        step(1, 1, 0, 0, "tp3");
        step(1, 1, 50, 0, "tp3");
        chk("tp3.sat_const", 32'(bus1.sat), 32'd1);
        chk("tp3.idx_const", 32'(bus1.peak_idx), 32'd2);

        // Narrow counter saturation with equal samples
        for (int i = 0; i < 6; i++) step(2, 1, 1, 0, "tp4");
        chk("tp4.count_const", 32'(bus2.count), 32'd3);
        chk("tp4.idx_const", 32'(bus2.peak_idx), 32'd0);

        // Random traffic on every configuration
        for (int s = 0; s < 3; s++) begin
            step(s, 0, 0, 1, "rnd_clr");
            for (int i = 0; i < 150; i++) begin
                v = ($urandom_range(0, 3) != 0);
                c = ($urandom_range(0, 19) == 0);
                r = $urandom_range(0, 9);
                if (r == 0) d = 0;
                else if (r == 1) d = (1 << w_a[s]) - 1;
                else d = $urandom_range(0, (1 << w_a[s]) - 1);
                step(s, v, d, c, "rnd");
            end
        end

        // Long run: new peaks arriving after the counter has saturated
        step(0, 0, 0, 1, "long_clr");
        for (int i = 0; i < 300; i++) begin
            d = (i < 260) ? $urandom_range(0, 100) : $urandom_range(101, 254);
            step(0, 1, d, 0, "long");
        end
        chk("long.count_const", 32'(bus0.count), 32'd255);
        chk("long.idx_const", 32'(bus0.peak_idx), 32'd255);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
